// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and FSM state encodings
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high;
// both flops reset to 1 so reset never looks like a start edge.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with a single-byte holding register,
// sticky framing-error and overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 UART_rxd,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_full,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_e state, state_n;

    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxd_s;
    logic                 half_end;
    logic                 bit_end;
    logic                 shift_en;
    logic                 byte_done;
    logic                 frame_bad;
    logic                 cnt_clr;
    logic                 load;
    logic                 over_set;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (UART_rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!rxd_s) state_n = START;
            START:   if (half_end) state_n = rxd_s ? IDLE : DATA;
            DATA:    if (shift_en && bit_cnt == BIT_LAST) state_n = STOP;
            STOP:    if (bit_end) state_n = rxd_s ? IDLE : BREAK;
            BREAK:   if (rxd_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        half_end  = baud_tick && (tick_cnt == CNT_HALF);
        bit_end   = baud_tick && (tick_cnt == CNT_LAST);
        shift_en  = (state == DATA) && bit_end;
        byte_done = (state == STOP) && bit_end && rxd_s;
        frame_bad = (state == STOP) && bit_end && !rxd_s;
        // Restart the tick count on every state change and bit boundary
        cnt_clr   = (state_n != state) || (state == IDLE)
                 || (state == BREAK) || bit_end;
        load      = byte_done && (!rx_full || rx_read);
        over_set  = byte_done && rx_full && !rx_read;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (cnt_clr)        tick_cnt <= '0;
            else if (baud_tick) tick_cnt <= tick_cnt + CW'(1);

            if (state != DATA)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + BW'(1);

            if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_full   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid <= load;

            if (load) begin
                rx_data <= shreg;
                rx_full <= 1'b1;
            end else if (rx_read) begin
                rx_full <= 1'b0;
            end

            // A flag raised in the same clk as rx_read stays set
            if (over_set)     overrun <= 1'b1;
            else if (rx_read) overrun <= 1'b0;

            if (frame_bad)    frame_err <= 1'b1;
            else if (rx_read) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames, expected bytes
// queued at issue time and checked by a monitor on every rx_valid.
module tb_uart_receiver;

    localparam int DIV = 4;
    localparam int OS  = 16;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       UART_rxd  = 1'b1;
    logic       rx_read   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         tests = 0;
    int         fails = 0;
    int         div   = 0;
    logic [7:0] exp_q[$];

    uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .UART_rxd  (UART_rxd),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_full   (rx_full),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div       <= (div == DIV - 1) ? 0 : div + 1;
        baud_tick <= (div == DIV - 2);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got rx_valid with %02h, expected none",
                         rx_data);
            end else begin
                check("sb_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic idle(input int n);
        UART_rxd = 1'b1;
        wait_ticks(n);
    endtask

    // Leaves the line at the stop level when it returns
    task automatic send_frame(input logic [7:0] d, input logic stop);
        UART_rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            UART_rxd = d[i];
            wait_ticks(OS);
        end
        UART_rxd = stop;
        wait_ticks(OS);
    endtask

    task automatic pulse_read;
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    // Raises rx_read for exactly the clk of the stop sample:
    // start falls at this negedge, START entered 3 clks later, then 152 ticks.
    task automatic read_at_done;
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (1) begin
            if (baud_tick) n++;
            if (n == OS / 2 + 9 * OS) break;
            @(negedge clk);
        end
        pulse_read();
    endtask

    task automatic wait_valid_then_read;
        int k;
        k = 0;
        while (!rx_valid && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_valid", {31'h0, rx_valid}, 32'h1);
        @(negedge clk);
        pulse_read();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_outputs",
              {20'h0, rx_data, rx_full, rx_valid, frame_err, overrun}, 32'h0);
        reset = 1'b0;
        idle(4);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5_full", {31'h0, rx_full}, 32'h1);
        check("a5_data", {24'h0, rx_data}, 32'hA5);
        check("a5_ferr", {31'h0, frame_err}, 32'h0);
        pulse_read();
        check("a5_read_clr", {31'h0, rx_full}, 32'h0);

        UART_rxd = 1'b0;
        wait_ticks(5);
        idle(20);
        check("false_start_full", {31'h0, rx_full}, 32'h0);

        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
                idle(4);
            end
            wait_valid_then_read();
        join
        check("b2b_data", {24'h0, rx_data}, 32'hC3);
        check("b2b_overrun", {31'h0, overrun}, 32'h0);
        pulse_read();

        send_frame(8'hFF, 1'b0);
        wait_ticks(40);
        check("fe_flag", {31'h0, frame_err}, 32'h1);
        check("fe_full", {31'h0, rx_full}, 32'h0);
        idle(2);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        idle(4);
        check("fe_next_data", {24'h0, rx_data}, 32'h96);
        check("fe_sticky", {31'h0, frame_err}, 32'h1);
        pulse_read();
        check("fe_clear", {31'h0, frame_err}, 32'h0);

        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(4);
        check("ov_flag", {31'h0, overrun}, 32'h1);
        check("ov_data_kept", {24'h0, rx_data}, 32'h11);
        check("ov_full", {31'h0, rx_full}, 32'h1);
        pulse_read();
        check("ov_full_clr", {31'h0, rx_full}, 32'h0);
        check("ov_clr", {31'h0, overrun}, 32'h0);

        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(4);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            read_at_done();
        join
        idle(4);
        check("coin_data", {24'h0, rx_data}, 32'h22);
        check("coin_full", {31'h0, rx_full}, 32'h1);
        check("coin_overrun", {31'h0, overrun}, 32'h0);

        UART_rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            UART_rxd = (8'h5A >> i) & 8'h01;
            wait_ticks(OS);
        end
        UART_rxd = 1'b1;
        wait_ticks(OS / 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_outputs",
              {20'h0, rx_data, rx_full, rx_valid, frame_err, overrun}, 32'h0);
        reset = 1'b0;
        idle(40);
        check("post_rst_outputs",
              {20'h0, rx_data, rx_full, rx_valid, frame_err, overrun}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(4);
        check("rst_next_data", {24'h0, rx_data}, 32'h81);
        check("rst_next_full", {31'h0, rx_full}, 32'h1);

        idle(8);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
